// File: rtl/tqvp_htfab_vga_fb.sv
// tqvp_htfab_vga_fb -- TinyQV peripheral: VGA framebuffer with RGB222 palette.
//
// Generates VGA timing from clk (one timing tick every TICK_DIV clocks), scans a
// COLS x ROWS framebuffer at BPP bits/pixel, maps pixels through a palette and
// drives a TinyVGA Pmod. Framebuffer access is indirect through PTR/DATA.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   address             byte address (register select on address[4:2])
//   data_in             write data
//   data_write_n        2'b10 = 32-bit write, anything else = no write
//   data_read_n         2'b11 = idle, anything else = read
//   data_out/data_ready read data with a one-cycle completion strobe
//   user_interrupt      sticky end-of-frame interrupt
//   uo_out              {hsync, B0, G0, R0, vsync, B1, G1, R1}
module tqvp_htfab_vga_fb #(
    parameter int COLS     = 32,
    parameter int ROWS     = 16,
    parameter int BPP      = 2,
    parameter int TICK_DIV = 2,
    parameter int H_VIS    = 768,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 96,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt,
    output logic [7:0]  uo_out
);
    localparam int WORDS  = COLS * ROWS * BPP / 32;
    localparam int PW     = H_VIS / COLS;
    localparam int PH     = V_VIS / ROWS;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int PTR_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PAL_W  = (1 << BPP) * 6;
    localparam int PPW_LG = (BPP == 2) ? 4 : 5;   // log2(pixels per word)
    localparam int HX_W   = $clog2(H_TOT + 1);
    localparam int VY_W   = $clog2(V_TOT + 1);
    localparam int CX_W   = $clog2(COLS + 1);
    localparam int RY_W   = $clog2(ROWS + 1);
    localparam int CS_W   = $clog2(PW + 1);
    localparam int RS_W   = $clog2(PH + 1);
    localparam int DIV_W  = $clog2(TICK_DIV + 1);

    localparam logic [HX_W-1:0]  HX_VIS   = HX_W'(H_VIS);
    localparam logic [HX_W-1:0]  HX_SS    = HX_W'(H_VIS + H_FP);
    localparam logic [HX_W-1:0]  HX_SE    = HX_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [HX_W-1:0]  HX_LAST  = HX_W'(H_TOT - 1);
    localparam logic [VY_W-1:0]  VY_VIS   = VY_W'(V_VIS);
    localparam logic [VY_W-1:0]  VY_VIS_M = VY_W'(V_VIS - 1);
    localparam logic [VY_W-1:0]  VY_SS    = VY_W'(V_VIS + V_FP);
    localparam logic [VY_W-1:0]  VY_SE    = VY_W'(V_VIS + V_FP + V_SYNC);
    localparam logic [VY_W-1:0]  VY_LAST  = VY_W'(V_TOT - 1);
    localparam logic [CS_W-1:0]  CS_LAST  = CS_W'(PW - 1);
    localparam logic [RS_W-1:0]  RS_LAST  = RS_W'(PH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WORDS - 1);
    localparam logic [31:0]      COLS_U   = 32'(COLS);
    localparam logic [31:0]      PPW_MASK = 32'(32 / BPP - 1);
    localparam logic [31:0]      BPP_U    = 32'(BPP);
    // Default palette: black, greys, white (only the low PAL_W bits are used).
    localparam logic [23:0]      PAL_RST  = (BPP == 2) ? 24'hFEA540 : 24'h000FC0;

    localparam logic [2:0] A_CTRL = 3'd0, A_PAL = 3'd1, A_PTR = 3'd2,
                           A_DATA = 3'd3, A_STATUS = 3'd4;

    logic [DIV_W-1:0] div_q, div_d;
    logic [HX_W-1:0]  hx_q, hx_d;
    logic [VY_W-1:0]  vy_q, vy_d;
    logic [CX_W-1:0]  col_q, col_d;
    logic [CS_W-1:0]  csub_q, csub_d;
    logic [RY_W-1:0]  row_q, row_d;
    logic [RS_W-1:0]  rsub_q, rsub_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [PAL_W-1:0] pal_q, pal_d;
    logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic             irq_q, irq_d;
    logic [15:0]      fc_q, fc_d;
    logic [7:0]       uo_q, uo_d;
    logic [31:0]      dout_q, dout_d;
    logic             rdy_q, rdy_d;
    logic [31:0]      fb_q [WORDS];

    logic             tick, frame_ev, vis, hs_act, vs_act;
    logic [31:0]      pix_lin, fb_word, rdata;
    logic [PTR_W-1:0] pix_word;
    logic [4:0]       pix_off;
    logic [BPP-1:0]   pix;
    logic [5:0]       rgb, colour;
    logic             wr, rd, fb_we;
    logic [2:0]       sel;
    logic             unused_addr;

    assign unused_addr = ^{address[5], address[1:0]};

    assign tick     = (div_q == DIV_LAST);
    // vy is about to become V_VIS at hx = 0: one event per frame.
    assign frame_ev = tick && (hx_q == HX_LAST) && (vy_q == VY_VIS_M);
    assign vis      = (hx_q < HX_VIS) && (vy_q < VY_VIS);
    assign hs_act   = (hx_q >= HX_SS) && (hx_q < HX_SE);
    assign vs_act   = (vy_q >= VY_SS) && (vy_q < VY_SE);

    // Timing counters. col/row advance through sub-counters while in the
    // visible area and then park at COLS/ROWS until the next line/frame.
    always_comb begin
        div_d  = tick ? '0 : div_q + 1'b1;
        hx_d   = hx_q;
        vy_d   = vy_q;
        col_d  = col_q;
        csub_d = csub_q;
        row_d  = row_q;
        rsub_d = rsub_q;
        if (tick) begin
            if (hx_q == HX_LAST) begin
                hx_d   = '0;
                col_d  = '0;
                csub_d = '0;
                if (vy_q == VY_LAST) begin
                    vy_d   = '0;
                    row_d  = '0;
                    rsub_d = '0;
                end else begin
                    vy_d = vy_q + 1'b1;
                    if (vy_q < VY_VIS) begin
                        if (rsub_q == RS_LAST) begin
                            rsub_d = '0;
                            row_d  = row_q + 1'b1;
                        end else begin
                            rsub_d = rsub_q + 1'b1;
                        end
                    end
                end
            end else begin
                hx_d = hx_q + 1'b1;
                if (hx_q < HX_VIS) begin
                    if (csub_q == CS_LAST) begin
                        csub_d = '0;
                        col_d  = col_q + 1'b1;
                    end else begin
                        csub_d = csub_q + 1'b1;
                    end
                end
            end
        end
    end

    // Pixel fetch; words per row are a power of two so word/offset are shifts.
    always_comb begin
        pix_lin  = 32'(row_q) * COLS_U + 32'(col_q);
        pix_word = PTR_W'(pix_lin >> PPW_LG);
        pix_off  = 5'((pix_lin & PPW_MASK) * BPP_U);
        fb_word  = fb_q[pix_word];
        pix      = fb_word[pix_off +: BPP];
        rgb      = 6'(pal_q >> (32'(pix) * 32'd6));
        colour   = (vis && ctrl_q[0]) ? rgb : 6'h00;
        uo_d     = {~hs_act, colour[0], colour[2], colour[4],
                    ~vs_act, colour[1], colour[3], colour[5]};
    end

    // Bus side: register writes, read mux, pointer auto-increment, IRQ.
    always_comb begin
        wr      = (data_write_n == 2'b10);
        rd      = (data_read_n != 2'b11);
        sel     = address[4:2];
        ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
        ctrl_d  = ctrl_q;
        pal_d   = pal_q;
        ptr_d   = ptr_q;
        fb_we   = 1'b0;
        fc_d    = frame_ev ? fc_q + 16'd1 : fc_q;
        irq_d   = irq_q;
        rdata   = 32'h0;
        if (wr) begin
            case (sel)
                A_CTRL: ctrl_d = data_in[1:0];
                A_PAL:  pal_d  = data_in[PAL_W-1:0];
                A_PTR:  ptr_d  = PTR_W'(data_in % WORDS);
                A_DATA: begin
                    fb_we = 1'b1;
                    ptr_d = ptr_inc;
                end
                A_STATUS: if (data_in[0]) irq_d = 1'b0;
                default: ;
            endcase
        end
        // Set after clear so a coincident set wins.
        if (frame_ev && ctrl_q[1]) irq_d = 1'b1;
        case (sel)
            A_CTRL:   rdata = 32'(ctrl_q);
            A_PAL:    rdata = 32'(pal_q);
            A_PTR:    rdata = 32'(ptr_q);
            A_DATA:   rdata = fb_q[ptr_q];
            A_STATUS: rdata = {fc_q, 13'b0, vy_q >= VY_VIS, hs_act, irq_q};
            default:  rdata = 32'h0;
        endcase
        dout_d = rd ? rdata : 32'h0;
        rdy_d  = rd;
        if (rd && sel == A_DATA) ptr_d = ptr_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= '0;
            hx_q   <= '0;
            vy_q   <= '0;
            col_q  <= '0;
            csub_q <= '0;
            row_q  <= '0;
            rsub_q <= '0;
            ctrl_q <= '0;
            pal_q  <= PAL_RST[PAL_W-1:0];
            ptr_q  <= '0;
            irq_q  <= 1'b0;
            fc_q   <= '0;
            uo_q   <= 8'b1000_1000;
            dout_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            hx_q   <= hx_d;
            vy_q   <= vy_d;
            col_q  <= col_d;
            csub_q <= csub_d;
            row_q  <= row_d;
            rsub_q <= rsub_d;
            ctrl_q <= ctrl_d;
            pal_q  <= pal_d;
            ptr_q  <= ptr_d;
            irq_q  <= irq_d;
            fc_q   <= fc_d;
            uo_q   <= uo_d;
            dout_q <= dout_d;
            rdy_q  <= rdy_d;
        end
    end

    // Framebuffer contents are not reset.
    always_ff @(posedge clk) begin
        if (fb_we) fb_q[ptr_q] <= data_in;
    end

    assign data_out       = dout_q;
    assign data_ready     = rdy_q;
    assign user_interrupt = irq_q;
    assign uo_out         = uo_q;
endmodule

// File: tb/tb_tqvp_htfab_vga_fb.sv
// Directed bench for tqvp_htfab_vga_fb. Geometry is scaled down so several
// frames fit in a short run: H 96/4/8/4 (1 line = 112 ticks, PW = 3),
// V 32/2/2/2 (1 frame = 38 lines, PH = 2), TICK_DIV = 2, 32x16 at 2 bpp.
// cyc counts clock edges since reset release; after edge k the counters hold
// tick T = k/2 and uo_out shows the picture for tick (k-1)/2.
module tb_tqvp_htfab_vga_fb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;
    logic [7:0]  uo_out;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc;

    localparam logic [5:0] A_CTRL = 6'h00, A_PAL = 6'h04, A_PTR = 6'h08,
                           A_DATA = 6'h0C, A_STATUS = 6'h10;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    tqvp_htfab_vga_fb #(
        .COLS(32), .ROWS(16), .BPP(2), .TICK_DIV(2),
        .H_VIS(96), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_VIS(32), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt), .uo_out(uo_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
        address = a; data_in = d; data_write_n = 2'b10;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic bus_rd(input string tag, input logic [5:0] a,
                          input logic [31:0] mask, input logic [31:0] exp);
        address = a; data_read_n = 2'b00;
        @(negedge clk);
        data_read_n = 2'b11;
        chk({tag, " ready"}, 32'(data_ready), 32'd1);
        chk(tag, data_out & mask, exp);
        @(negedge clk);
        chk({tag, " ready drop"}, 32'(data_ready), 32'd0);
        chk({tag, " data drop"}, data_out, 32'd0);
    endtask

    task automatic uo_at(input string tag, input int n, input logic [7:0] exp);
        goto(n);
        chk(tag, 32'(uo_out), 32'(exp));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst ready", 32'(data_ready), 32'd0);
        chk("rst data", data_out, 32'd0);
        chk("rst uo", 32'(uo_out), 32'h88);
        chk("rst irq", 32'(user_interrupt), 32'd0);

        // Register file and indirect framebuffer access.
        bus_rd("status rst", A_STATUS, ALL, 32'h0);
        bus_rd("pal rst", A_PAL, ALL, 32'h00FE_A540);
        bus_rd("unmapped", 6'h14, ALL, 32'h0);
        bus_wr(A_CTRL, ALL);
        bus_rd("ctrl bits", A_CTRL, ALL, 32'h3);
        bus_wr(A_PTR, 32'd33);
        bus_rd("ptr mod", A_PTR, ALL, 32'd1);
        bus_wr(A_PTR, 32'd31);
        bus_wr(A_DATA, 32'hAAAA_5555);
        bus_wr(A_DATA, 32'h1234_5678);
        bus_rd("ptr wrap", A_PTR, ALL, 32'd1);
        bus_wr(A_PTR, 32'd0);
        bus_wr(A_DATA, 32'h1B);
        bus_wr(A_DATA, 32'hFF);
        bus_rd("ptr after 2 wr", A_PTR, ALL, 32'd2);
        bus_wr(A_PTR, 32'd0);
        // Back-to-back DATA reads, each with its own strobe.
        address = A_DATA; data_read_n = 2'b10;
        @(negedge clk);
        data_read_n = 2'b01;
        chk("b2b ready0", 32'(data_ready), 32'd1);
        chk("b2b data0", data_out, 32'h1B);
        @(negedge clk);
        data_read_n = 2'b11;
        chk("b2b ready1", 32'(data_ready), 32'd1);
        chk("b2b data1", data_out, 32'hFF);
        @(negedge clk);
        chk("b2b ready drop", 32'(data_ready), 32'd0);
        bus_rd("ptr after 2 rd", A_PTR, ALL, 32'd2);
        bus_wr(A_PTR, 32'd31);
        bus_rd("fb31", A_DATA, ALL, 32'hAAAA_5555);
        bus_rd("ptr rd wrap", A_PTR, ALL, 32'd0);
        bus_wr(A_PTR, 32'd1);
        bus_wr(A_DATA, 32'hC000_0001);
        bus_wr(A_DATA, 32'h0000_0002);
        bus_wr(A_PAL, ALL);
        bus_rd("pal unused 0", A_PAL, ALL, 32'h00FF_FFFF);
        bus_wr(A_PAL, 32'h00FE_A540);
        bus_wr(A_CTRL, 32'h1);

        // Frame 0 ends at edge 7168 with irq_en = 0: counter only.
        uo_at("f0 before ev", 7168, 8'h88);
        chk("f0 no irq", 32'(user_interrupt), 32'd0);
        goto(7199);
        bus_rd("status vblank", A_STATUS, ALL, 32'h0001_0004);
        bus_wr(A_CTRL, 32'h3);

        // Frame 1 picture (fb[0]=1B -> 3F,2A,15,00; fb[1]=C0000001; fb[2]=2).
        uo_at("px0", 8515, 8'hFF);
        uo_at("px0 end", 8518, 8'hFF);
        uo_at("px1 start", 8519, 8'h8F);
        uo_at("px1", 8521, 8'h8F);
        uo_at("px2", 8527, 8'hF8);
        uo_at("px3", 8533, 8'h88);
        uo_at("px16", 8611, 8'hF8);
        uo_at("px31", 8703, 8'hFF);
        uo_at("hblank", 8705, 8'h88);
        uo_at("pre hsync", 8711, 8'h88);
        uo_at("hsync start", 8713, 8'h08);
        uo_at("hsync end", 8727, 8'h08);
        uo_at("post hsync", 8729, 8'h88);
        uo_at("row1 px0", 8963, 8'h8F);

        // End of frame 1 with irq_en = 1.
        goto(15679);
        chk("irq before ev", 32'(user_interrupt), 32'd0);
        goto(15680);
        chk("irq rise", 32'(user_interrupt), 32'd1);
        uo_at("vblank px", 15683, 8'h88);
        uo_at("pre vsync", 15905, 8'h88);
        uo_at("vsync start", 16129, 8'h80);
        uo_at("vsync+hsync", 16329, 8'h00);
        uo_at("vsync end", 16353, 8'h80);
        uo_at("post vsync", 16577, 8'h88);
        bus_rd("status f1", A_STATUS, 32'hFFFF_0001, 32'h0002_0001);
        goto(20000);
        bus_wr(A_STATUS, 32'h0);
        chk("irq held", 32'(user_interrupt), 32'd1);

        // Clear coincides with the frame 2 set: set wins.
        goto(24191);
        bus_wr(A_STATUS, 32'h1);
        chk("set wins", 32'(user_interrupt), 32'd1);
        goto(24300);
        bus_wr(A_STATUS, 32'h1);
        chk("irq clear", 32'(user_interrupt), 32'd0);
        bus_rd("status f2", A_STATUS, 32'hFFFF_0001, 32'h0003_0000);

        // Display disabled: frame 3 row 0 shows black.
        bus_wr(A_CTRL, 32'h0);
        uo_at("disabled px0", 25539, 8'h88);
        bus_wr(A_CTRL, 32'h2);
        goto(32703);
        chk("irq f3 before", 32'(user_interrupt), 32'd0);
        goto(32704);
        chk("irq f3 rise", 32'(user_interrupt), 32'd1);
        bus_wr(A_CTRL, 32'h3);
        uo_at("f4 px0", 34051, 8'hFF);

        // Reset mid-line with a read in flight.
        address = A_STATUS; data_read_n = 2'b00;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst ready", 32'(data_ready), 32'd0);
        chk("midrst data", data_out, 32'd0);
        chk("midrst uo", 32'(uo_out), 32'h88);
        chk("midrst irq", 32'(user_interrupt), 32'd0);
        data_read_n = 2'b11;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post rst ready", 32'(data_ready), 32'd0);
        @(negedge clk);
        chk("post rst ready2", 32'(data_ready), 32'd0);
        uo_at("restart pre hsync", 199, 8'h88);
        uo_at("restart hsync", 201, 8'h08);
        bus_rd("ctrl after rst", A_CTRL, ALL, 32'h0);
        bus_rd("ptr after rst", A_PTR, ALL, 32'h0);
        bus_rd("pal after rst", A_PAL, ALL, 32'h00FE_A540);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
